// File: rtl/controlador_jugada_if.sv
// Player-input / board-state bundle between the turn stage, this controller,
// and the win-checker and display stages.
interface controlador_jugada_if #(
  parameter int COLS = 7,
  parameter int ROWS = 6
);
  logic                     pressIzq;
  logic                     pressDer;
  logic                     pressEnt;
  logic                     lock;
  logic [2:0]               cursor;
  logic                     turno;
  logic [2*ROWS*COLS-1:0]   tablero;
  logic [2:0]               last_row;
  logic [2:0]               last_col;
  logic                     move_done;
  logic                     col_full;
  logic                     board_full;
  logic                     busy;

  modport master (
    output pressIzq, pressDer, pressEnt, lock,
    input  cursor, turno, tablero, last_row, last_col,
           move_done, col_full, board_full, busy
  );

  modport slave (
    input  pressIzq, pressDer, pressEnt, lock,
    output cursor, turno, tablero, last_row, last_col,
           move_done, col_full, board_full, busy
  );
endinterface

// File: rtl/controlador_jugada.sv
// Connect4 move controller: moves the column cursor, scans the column bottom-up
// one row per cycle, and drops the current player's piece into the lowest empty cell.
module controlador_jugada #(
  parameter int COLS = 7,
  parameter int ROWS = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  controlador_jugada_if.slave   bus
);
  localparam int IW   = $clog2(2*ROWS*COLS);
  localparam int CNTW = $clog2(ROWS*COLS+1);

  typedef enum logic [1:0] {IDLE, SCAN, WRITE} state_t;

  state_t          state;
  logic [2:0]      selCol;
  logic [2:0]      row;
  logic [CNTW-1:0] pieceCnt;
  logic [IW-1:0]   cellIdx;

  // SCAN and WRITE both address the same cell, so one index serves both.
  always_comb begin
    cellIdx = IW'(2*(int'(row)*COLS + int'(selCol)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      selCol         <= '0;
      row            <= '0;
      pieceCnt       <= '0;
      bus.cursor     <= 3'(COLS/2);
      bus.turno      <= 1'b0;
      bus.tablero    <= '0;
      bus.last_row   <= '0;
      bus.last_col   <= '0;
      bus.move_done  <= 1'b0;
      bus.col_full   <= 1'b0;
      bus.board_full <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      bus.move_done <= 1'b0;
      bus.col_full  <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.lock && !bus.board_full) begin
            if (bus.pressIzq) begin
              if (bus.cursor != 3'd0) bus.cursor <= bus.cursor - 3'd1;
            end else if (bus.pressDer) begin
              if (bus.cursor != 3'(COLS-1)) bus.cursor <= bus.cursor + 3'd1;
            end else if (bus.pressEnt) begin
              selCol   <= bus.cursor;
              row      <= '0;
              state    <= SCAN;
              bus.busy <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (bus.tablero[cellIdx +: 2] == 2'b00) begin
            state <= WRITE;
          end else if (row == 3'(ROWS-1)) begin
            bus.col_full <= 1'b1;
            state        <= IDLE;
            bus.busy     <= 1'b0;
          end else begin
            row <= row + 3'd1;
          end
        end
        WRITE: begin
          bus.tablero[cellIdx +: 2] <= bus.turno ? 2'b10 : 2'b01;
          bus.last_row  <= row;
          bus.last_col  <= selCol;
          bus.move_done <= 1'b1;
          bus.turno     <= ~bus.turno;
          pieceCnt      <= pieceCnt + 1'b1;
          if (pieceCnt == CNTW'(ROWS*COLS-1)) bus.board_full <= 1'b1;
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_controlador_jugada.sv
// Self-checking bench: cursor vector table plus a scoreboard of expected drop results.
module tb_controlador_jugada;
  localparam int COLS = 7;
  localparam int ROWS = 6;
  localparam int NB   = 2*ROWS*COLS;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  controlador_jugada_if #(.COLS(COLS), .ROWS(ROWS)) bus ();
  controlador_jugada #(.COLS(COLS), .ROWS(ROWS)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic       izq, der, ent;
    logic [2:0] expCur;
    logic       expBusy;
  } vec_t;

  typedef struct {
    logic       full;
    logic [2:0] row, col;
    int         lat;
    logic [1:0] piece;
  } exp_t;

  exp_t       sbq[$];
  logic [1:0] mb[ROWS][COLS];
  logic       mTurno;
  int         mCnt;
  int         mCur;
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chkBoard(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [NB-1:0] modelBoard();
    logic [NB-1:0] v = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        v[2*(r*COLS+c) +: 2] = mb[r][c];
    return v;
  endfunction

  task automatic modelReset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) mb[r][c] = 2'b00;
    mTurno = 1'b0; mCnt = 0; mCur = COLS/2;
    sbq.delete();
  endtask

  task automatic press(input logic izq, input logic der);
    @(negedge clk);
    bus.pressIzq = izq; bus.pressDer = der;
    @(negedge clk);
    bus.pressIzq = 1'b0; bus.pressDer = 1'b0;
    if (!bus.lock && mCnt < ROWS*COLS) begin
      if (izq) mCur = (mCur > 0) ? mCur - 1 : 0;
      else if (der) mCur = (mCur < COLS-1) ? mCur + 1 : COLS-1;
    end
  endtask

  task automatic gotoCol(input int c);
    while (mCur > c) press(1'b1, 1'b0);
    while (mCur < c) press(1'b0, 1'b1);
    chk("cursor_goto", bus.cursor, c);
  endtask

  // Pulse enter and push the expected outcome derived from the bench's own board model.
  task automatic startDrop();
    exp_t e;
    int k = 0;
    while (k < ROWS && mb[k][mCur] != 2'b00) k++;
    e.full  = (k == ROWS);
    e.row   = 3'(e.full ? 0 : k);
    e.col   = 3'(mCur);
    e.lat   = e.full ? ROWS : k + 2;
    e.piece = mTurno ? 2'b10 : 2'b01;
    sbq.push_back(e);
    @(negedge clk); bus.pressEnt = 1'b1;
    @(negedge clk); bus.pressEnt = 1'b0;
  endtask

  task automatic waitDone(input int already);
    exp_t e;
    int n = already;
    bit got = 0;
    while (!got && n < 20) begin
      @(posedge clk); #1; n++;
      if (bus.move_done || bus.col_full) got = 1;
    end
    e = sbq.pop_front();
    if (!got) begin
      total++; bad++;
      $display("FAIL drop_timeout: no move_done/col_full within %0d edges", n);
      return;
    end
    chk("latency", n, e.lat);
    chk("col_full", bus.col_full, e.full);
    chk("move_done", bus.move_done, !e.full);
    chk("busy_after", bus.busy, 0);
    if (!e.full) begin
      mb[e.row][e.col] = e.piece;
      mTurno = ~mTurno;
      mCnt++;
      chk("last_row", bus.last_row, e.row);
      chk("last_col", bus.last_col, e.col);
    end
    chkBoard("tablero", bus.tablero, modelBoard());
    chk("turno", bus.turno, mTurno);
    chk("board_full", bus.board_full, mCnt == ROWS*COLS);
    chk("cursor_frozen", bus.cursor, mCur);
  endtask

  task automatic drop();
    startDrop();
    waitDone(0);
  endtask

  // Expect a quiet controller for n cycles: no busy, no pulses.
  task automatic quiet(input string name, input int n);
    int hits = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (bus.busy || bus.move_done || bus.col_full) hits++;
    end
    chk(name, hits, 0);
  endtask

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 3'd2, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 3'd1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 3'd1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 3'd2, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 3'd3, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 3'd4, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 3'd5, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 3'd6, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 3'd6, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 3'd6, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 3'd5, 1'b0};  // Izq beats Der
    tbl[13] = '{1'b0, 1'b1, 1'b1, 3'd6, 1'b0};  // Der beats Ent

    bus.pressIzq = 1'b0; bus.pressDer = 1'b0; bus.pressEnt = 1'b0; bus.lock = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_cursor", bus.cursor, 3);
    chk("rst_turno", bus.turno, 0);
    chkBoard("rst_tablero", bus.tablero, '0);
    chk("rst_last", {bus.last_row, bus.last_col}, 0);
    chk("rst_pulses", {bus.move_done, bus.col_full, bus.board_full, bus.busy}, 0);

    // Cursor vectors
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      bus.pressIzq = tbl[i].izq; bus.pressDer = tbl[i].der; bus.pressEnt = tbl[i].ent;
      @(negedge clk);
      bus.pressIzq = 1'b0; bus.pressDer = 1'b0; bus.pressEnt = 1'b0;
      chk($sformatf("cursor_vec%0d", i), bus.cursor, tbl[i].expCur);
      chk($sformatf("busy_vec%0d", i), bus.busy, tbl[i].expBusy);
    end
    mCur = 6;
    quiet("no_drop_on_der_ent", 4);

    // Two drops in the middle column
    gotoCol(3);
    drop();
    drop();

    // Fill column 0, then a rejected drop
    gotoCol(0);
    repeat (ROWS) drop();
    drop();

    // Presses while scanning are dropped and the cursor stays put
    gotoCol(3);
    startDrop();
    bus.pressDer = 1'b1; bus.pressEnt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.pressDer = 1'b0; bus.pressEnt = 1'b0;
    waitDone(1);
    quiet("no_queued_drop", 8);

    // Lock blocks everything
    bus.lock = 1'b1;
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    @(negedge clk); bus.pressEnt = 1'b1;
    @(negedge clk); bus.pressEnt = 1'b0;
    quiet("lock_quiet", 6);
    chk("lock_cursor", bus.cursor, 3);
    chkBoard("lock_tablero", bus.tablero, modelBoard());
    bus.lock = 1'b0;

    // Reset mid-scan aborts the move
    startDrop();
    @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    modelReset();
    @(negedge clk);
    chkBoard("abort_tablero", bus.tablero, '0);
    chk("abort_turno", bus.turno, 0);
    chk("abort_cursor", bus.cursor, 3);
    quiet("abort_quiet", 6);

    // Fill the whole board
    for (int c = 0; c < COLS; c++) begin
      gotoCol(c);
      for (int r = 0; r < ROWS; r++) drop();
    end
    chk("board_full_level", bus.board_full, 1);
    @(negedge clk); bus.pressEnt = 1'b1;
    @(negedge clk); bus.pressEnt = 1'b0;
    quiet("full_quiet", 8);
    chk("full_stays", bus.board_full, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
